// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller pipeline signal bundle
interface pipe_hazard_ctrl_if;
   logic [4:0]  d_rs;
   logic [4:0]  d_rt;
   logic [1:0]  d_tuse_rs;
   logic [1:0]  d_tuse_rt;
   logic [4:0]  e_wa;
   logic [4:0]  m_wa;
   logic [1:0]  e_tnew;
   logic [1:0]  m_tnew;
   logic        d_md;
   logic        e_md_start;
   logic        e_md_div;
   logic        d_eret;
   logic        e_epc_wr;
   logic        m_epc_wr;
   logic        exc_req;
   logic        pc_we;
   logic        fd_we;
   logic        de_we;
   logic        fd_clear;
   logic        de_clear;
   logic        em_clear;
   logic        mw_clear;
   logic        stall;
   logic        md_busy;
   logic [31:0] stall_cnt;

   modport master (
      output d_rs, d_rt, d_tuse_rs, d_tuse_rt, e_wa, m_wa, e_tnew, m_tnew,
             d_md, e_md_start, e_md_div, d_eret, e_epc_wr, m_epc_wr, exc_req,
      input  pc_we, fd_we, de_we, fd_clear, de_clear, em_clear, mw_clear,
             stall, md_busy, stall_cnt
   );

   modport slave (
      input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, e_wa, m_wa, e_tnew, m_tnew,
             d_md, e_md_start, e_md_div, d_eret, e_epc_wr, m_epc_wr, exc_req,
      output pc_we, fd_we, de_we, fd_clear, de_clear, em_clear, mw_clear,
             stall, md_busy, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - D-stage stall/flush control with mult/div busy tracking
// Optional stall counter enabled by PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl (
   input logic                clk,
   input logic                reset,
   pipe_hazard_ctrl_if.slave  hz
);

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       md_busy;
   logic       rs_hazard, rt_hazard, md_hazard, eret_hazard;
   logic       stall;

   function automatic logic reg_hazard(
      input logic [4:0] r,
      input logic [1:0] tuse,
      input logic [4:0] e_wa,
      input logic [1:0] e_tnew,
      input logic [4:0] m_wa,
      input logic [1:0] m_tnew
   );
      return (r != 5'd0) && (tuse != 2'd3) &&
             (((r == e_wa) && (tuse < e_tnew)) || ((r == m_wa) && (tuse < m_tnew)));
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A start during BUSY cannot reach E legally, so it is simply ignored there.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (hz.e_md_start && !hz.exc_req) begin
               state_d = BUSY;
               cnt_d   = hz.e_md_div ? 4'd10 : 4'd5;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign md_busy = (state_q == BUSY) && !reset;

   assign rs_hazard   = reg_hazard(hz.d_rs, hz.d_tuse_rs, hz.e_wa, hz.e_tnew, hz.m_wa, hz.m_tnew);
   assign rt_hazard   = reg_hazard(hz.d_rt, hz.d_tuse_rt, hz.e_wa, hz.e_tnew, hz.m_wa, hz.m_tnew);
   assign md_hazard   = hz.d_md && (md_busy || hz.e_md_start);
   assign eret_hazard = hz.d_eret && (hz.e_epc_wr || hz.m_epc_wr);
   assign stall       = (rs_hazard || rt_hazard || md_hazard || eret_hazard) &&
                        !hz.exc_req && !reset;

   // Priority: flush (reset/exception) over stall over eret delay-slot kill.
   always_comb begin
      hz.pc_we    = 1'b1;
      hz.fd_we    = 1'b1;
      hz.de_we    = 1'b1;
      hz.fd_clear = 1'b0;
      hz.de_clear = 1'b0;
      hz.em_clear = 1'b0;
      hz.mw_clear = 1'b0;
      if (reset || hz.exc_req) begin
         hz.fd_clear = 1'b1;
         hz.de_clear = 1'b1;
         hz.em_clear = 1'b1;
         hz.mw_clear = 1'b1;
      end else if (stall) begin
         hz.pc_we    = 1'b0;
         hz.fd_we    = 1'b0;
         hz.de_clear = 1'b1;
      end else if (hz.d_eret) begin
         hz.fd_clear = 1'b1;
      end
   end

   assign hz.stall   = stall;
   assign hz.md_busy = md_busy;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt_q <= 32'd0;
      else if (stall)
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign hz.stall_cnt = stall_cnt_q;
`else
   assign hz.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and randomized checks against a behavioural model
module tb_pipe_hazard_ctrl;

   logic clk;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: remaining busy cycles of the mult/div unit and expected stall count
   int          rem = 0;
   logic [31:0] exp_cnt = 32'd0;
   logic        cnt_known = 1'b0;
   logic        exp_stall = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic reg_conflict(input logic [4:0] r, input logic [1:0] tuse);
      if (r == 0 || tuse == 3) return 1'b0;
      if (r == hz.e_wa && int'(tuse) < int'(hz.e_tnew)) return 1'b1;
      if (r == hz.m_wa && int'(tuse) < int'(hz.m_tnew)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic clear_inputs();
      hz.d_rs = 0; hz.d_rt = 0; hz.d_tuse_rs = 3; hz.d_tuse_rt = 3;
      hz.e_wa = 0; hz.m_wa = 0; hz.e_tnew = 0; hz.m_tnew = 0;
      hz.d_md = 0; hz.e_md_start = 0; hz.e_md_div = 0;
      hz.d_eret = 0; hz.e_epc_wr = 0; hz.m_epc_wr = 0; hz.exc_req = 0;
   endtask

   // Settle, then compare every output with the model's view of this cycle
   task automatic apply();
      logic busy, hazard;
      logic [8:0] expv, obsv;
      #1;
      busy   = !reset && rem > 0;
      hazard = reg_conflict(hz.d_rs, hz.d_tuse_rs) || reg_conflict(hz.d_rt, hz.d_tuse_rt) ||
               (hz.d_md && (busy || hz.e_md_start)) ||
               (hz.d_eret && (hz.e_epc_wr || hz.m_epc_wr));
      exp_stall = hazard && !hz.exc_req && !reset;
      // order: stall md_busy pc_we fd_we de_we fd_clr de_clr em_clr mw_clr
      if (reset || hz.exc_req)  expv = {exp_stall, busy, 7'b111_1111};
      else if (exp_stall)       expv = {exp_stall, busy, 7'b001_0100};
      else if (hz.d_eret)       expv = {exp_stall, busy, 7'b111_1000};
      else                      expv = {exp_stall, busy, 7'b111_0000};
      obsv = {hz.stall, hz.md_busy, hz.pc_we, hz.fd_we, hz.de_we,
              hz.fd_clear, hz.de_clear, hz.em_clear, hz.mw_clear};
      chk("ctrl_vector", 32'(obsv), 32'(expv));
      if (cnt_known) chk("stall_cnt", hz.stall_cnt, exp_cnt);
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         rem = 0;
         exp_cnt = 32'd0;
         cnt_known = 1'b1;
      end else begin
         if (rem > 0) rem--;
         else if (hz.e_md_start && !hz.exc_req) rem = hz.e_md_div ? 10 : 5;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
         if (exp_stall) exp_cnt = exp_cnt + 32'd1;
`endif
      end
      #1;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      apply();
      chk("reset_stall", 32'(hz.stall), 32'd0);
      chk("reset_flush", 32'({hz.fd_clear, hz.de_clear, hz.em_clear, hz.mw_clear}), 32'hF);
      tick();
      hz.d_md = 1; hz.e_md_start = 1;
      apply();
      chk("reset_md_start_stall", 32'(hz.stall), 32'd0);
      tick();
      reset = 1'b0;
      clear_inputs();
      apply();
      chk("post_reset_busy", 32'(hz.md_busy), 32'd0);
      tick();

      // load-use
      hz.d_rs = 5; hz.d_tuse_rs = 0; hz.e_wa = 5; hz.e_tnew = 2;
      apply();
      chk("load_use_stall", 32'({hz.stall, hz.pc_we, hz.fd_we, hz.de_clear}), 32'b1001);
      tick();
      hz.d_rs = 0;
      apply();
      chk("r0_no_stall", 32'(hz.stall), 32'd0);
      tick();
      clear_inputs();

      // mult then mfhi
      hz.d_md = 1; hz.e_md_start = 1; hz.e_md_div = 0;
      apply();
      chk("mult_start_stall", 32'(hz.stall), 32'd1);
      tick();
      hz.e_md_start = 0;
      for (int i = 0; i < 5; i++) begin
         apply();
         chk("mult_busy", 32'({hz.md_busy, hz.stall}), 32'b11);
         tick();
      end
      apply();
      chk("mult_done", 32'({hz.md_busy, hz.stall}), 32'b00);
      tick();
      clear_inputs();

      // div aborted by exception with a coincident load-use
      hz.e_md_start = 1; hz.e_md_div = 1; hz.exc_req = 1;
      hz.d_rs = 5; hz.d_tuse_rs = 0; hz.e_wa = 5; hz.e_tnew = 2;
      apply();
      chk("abort_flush", 32'({hz.stall, hz.pc_we, hz.fd_clear, hz.de_clear, hz.em_clear, hz.mw_clear}), 32'b011111);
      tick();
      clear_inputs();
      apply();
      chk("abort_not_busy", 32'(hz.md_busy), 32'd0);
      tick();

      // eret after mtc0 EPC
      hz.d_eret = 1; hz.e_epc_wr = 1;
      apply();
      chk("eret_e_stall", 32'(hz.stall), 32'd1);
      tick();
      hz.e_epc_wr = 0; hz.m_epc_wr = 1;
      apply();
      chk("eret_m_stall", 32'(hz.stall), 32'd1);
      tick();
      hz.m_epc_wr = 0;
      apply();
      chk("eret_nullify", 32'({hz.stall, hz.fd_clear, hz.pc_we}), 32'b011);
      tick();
      clear_inputs();

      // reset in the middle of a div
      hz.e_md_start = 1; hz.e_md_div = 1;
      apply();
      tick();
      hz.e_md_start = 0;
      apply(); tick();
      apply(); tick();
      reset = 1'b1;
      apply(); tick();
      reset = 1'b0;
      apply();
      chk("reset_mid_div_busy", 32'(hz.md_busy), 32'd0);
      chk("reset_mid_div_cnt", hz.stall_cnt, 32'd0);
      tick();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
      hz.d_eret = 1; hz.e_epc_wr = 1;
      for (int i = 0; i < 7; i++) begin
         apply(); tick();
      end
      clear_inputs();
      apply();
      chk("perf_seven", hz.stall_cnt, 32'd7);
      tick();
      dut.stall_cnt_q = 32'hFFFF_FFFE;
      exp_cnt = 32'hFFFF_FFFE;
      hz.d_eret = 1; hz.e_epc_wr = 1;
      apply(); tick();
      apply(); tick();
      clear_inputs();
      apply();
      chk("perf_wrap", hz.stall_cnt, 32'd0);
      tick();
`endif

      // randomized traffic with small register numbers to force collisions
      for (int i = 0; i < 600; i++) begin
         hz.d_rs       = 5'($urandom_range(0, 3));
         hz.d_rt       = 5'($urandom_range(0, 3));
         hz.d_tuse_rs  = 2'($urandom_range(0, 3));
         hz.d_tuse_rt  = 2'($urandom_range(0, 3));
         hz.e_wa       = 5'($urandom_range(0, 3));
         hz.m_wa       = 5'($urandom_range(0, 3));
         hz.e_tnew     = 2'($urandom_range(0, 3));
         hz.m_tnew     = 2'($urandom_range(0, 3));
         hz.d_md       = ($urandom_range(0, 3) == 0);
         hz.e_md_start = ($urandom_range(0, 7) == 0);
         hz.e_md_div   = 1'($urandom_range(0, 1));
         hz.d_eret     = ($urandom_range(0, 5) == 0);
         hz.e_epc_wr   = ($urandom_range(0, 3) == 0);
         hz.m_epc_wr   = ($urandom_range(0, 3) == 0);
         hz.exc_req    = ($urandom_range(0, 9) == 0);
         reset         = ($urandom_range(0, 59) == 0);
         apply();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: clk input 1 (all state changes on rising edge); reset input 1.
REQ-002 d_rs, d_rt SHALL be inputs, 5 bits each: D-stage source register numbers.
REQ-003 d_tuse_rs, d_tuse_rt SHALL be inputs, 2 bits each: cycles until the operand is needed; 3 means the operand is unused.
REQ-004 e_wa, m_wa SHALL be inputs, 5 bits each: E/M-stage destination register numbers.
REQ-005 e_tnew, m_tnew SHALL be inputs, 2 bits each: cycles until the E/M result is available.
REQ-006 d_md SHALL be a 1-bit input: the D instruction uses the mult/div unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-007 e_md_start input 1: mult/div issued in E; e_md_div input 1: 1=div, 0=mult.
REQ-008 d_eret input 1; e_epc_wr, m_epc_wr inputs 1: E/M-stage mtc0 targeting EPC (reg 14).
REQ-009 exc_req input 1: exception/interrupt taken at M stage.
REQ-010 pc_we, fd_we, de_we outputs 1: write enables for PC, F/D and D/E registers.
REQ-011 fd_clear, de_clear, em_clear, mw_clear outputs 1: pipeline-register clears.
REQ-012 stall output 1: D-stage stall; md_busy output 1: mult/div unit occupied.
REQ-013 stall_cnt output 32: count of stall cycles (see Configuration).

Function
REQ-014 A register hazard SHALL be flagged for rs when d_rs!=0, d_tuse_rs!=3 and either (d_rs==e_wa and d_tuse_rs<e_tnew) or (d_rs==m_wa and d_tuse_rs<m_tnew); the same rule SHALL apply to rt.
REQ-015 An MD hazard SHALL be flagged when d_md=1 and (md_busy=1 or e_md_start=1).
REQ-016 An ERET hazard SHALL be flagged when d_eret=1 and (e_epc_wr=1 or m_epc_wr=1).
REQ-017 stall SHALL be the OR of all hazards, masked to 0 when exc_req=1 or reset=1.
REQ-018 On stall=1: pc_we=0, fd_we=0, de_clear=1, de_we=1, em/mw/fd_clear=0, all combinationally in the same cycle.
REQ-019 On exc_req=1, regardless of hazards: pc_we=1, fd_we=1, de_we=1, fd_clear=de_clear=em_clear=mw_clear=1.
REQ-020 On d_eret=1 with stall=0 and exc_req=0: fd_clear=1 (delay slot nullified), pc_we=1.
REQ-021 Otherwise: pc_we=fd_we=de_we=1 and all clears=0.
REQ-022 MD sequencing SHALL be a 4-bit down-counter with FSM states IDLE (count=0) and BUSY (count!=0); md_busy=1 exactly in BUSY.
REQ-023 IDLE->BUSY: when e_md_start=1 and exc_req=0, the counter SHALL load 5 (mult) or 10 (div) at the edge; md_busy SHALL be 1 for exactly 5/10 cycles following that edge.
REQ-024 BUSY SHALL decrement by 1 per cycle and return to IDLE at 0; e_md_start while BUSY cannot occur (blocked by REQ-015) and SHALL be ignored.
REQ-025 e_md_start coincident with exc_req SHALL NOT load the counter; an already-running count SHALL continue unaffected by exc_req.

Reset
REQ-026 While reset=1: stall=0, md_busy=0, pc_we=fd_we=de_we=1, all four clears=1.
REQ-027 At a clock edge with reset=1: counter=0 (IDLE) and stall_cnt=0, overriding any in-flight mult/div or simultaneous e_md_start.

Configuration
REQ-028 Macro PIPE_HAZARD_CTRL_PERF_EN defined: stall_cnt SHALL increment by 1 at each edge where stall=1, wrapping 0xFFFFFFFF->0.
REQ-029 PIPE_HAZARD_CTRL_PERF_EN undefined: stall_cnt SHALL be constant 0 with no counter register; all other behaviour SHALL be identical.

Verification
REQ-030 Load-use: d_rs=5, d_tuse_rs=0, e_wa=5, e_tnew=2 -> stall=1, pc_we=0, fd_we=0, de_clear=1; with d_rs=0 -> stall=0.
REQ-031 mult then mfhi: e_md_start=1, e_md_div=0 -> md_busy=1 for 5 cycles; d_md=1 held -> stall=1 for the start cycle plus 5 cycles, then 0.
REQ-032 div aborted: e_md_start=1 with exc_req=1 -> md_busy stays 0; all four clears=1, pc_we=1, stall=0 despite a simultaneous load-use hazard.
REQ-033 eret after mtc0 EPC: d_eret=1, e_epc_wr=1 -> stall=1; next cycle m_epc_wr=1 -> stall=1; then fd_clear=1, stall=0.
REQ-034 Reset mid-div: reset at cycle 3 of div -> md_busy=0 next cycle; stall_cnt=0 (PERF_EN build).
REQ-035 PERF_EN: 7 stall cycles -> stall_cnt=7; preload near 0xFFFFFFFF via stalls/force -> wraps to 0.
